// File: rtl/core_pkg.sv
// Shared core definitions for the hazard controller.
//   hz_state_t / HZ_*   : hazard FSM state type and encodings
//   REG_W               : architectural register index width
//   STAT_W              : width of the optional statistics counters
//   CNT_W               : width of the memory wait counter
package core_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned STAT_W = 16;
  localparam int unsigned CNT_W  = 8;

  typedef logic [1:0] hz_state_t;

  localparam hz_state_t HZ_RUN      = 2'b00;
  localparam hz_state_t HZ_LU_STALL = 2'b01;
  localparam hz_state_t HZ_MEM_WAIT = 2'b10;

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// sat_counter: width-parameterised up counter that sticks at all-ones.
//   clk   in  : clock
//   clr   in  : synchronous clear (wins over inc)
//   inc   in  : count enable
//   count out : registered count value
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: ID-stage pipeline hazard controller (load-use stall,
// taken-branch squash, data-memory wait freeze).
//   Parameter MEM_TIMEOUT (1..255): wait cycles before mem_timeout pulses.
//   Inputs : clk, rst (sync, active-high), id_rs1/id_rs2, id_use_rs1/id_use_rs2,
//            ex_rd, ex_memread, branch_taken, mem_req, mem_ready
//   Outputs: pc_en, ifid_en, ifid_flush, bubble, pipe_en (combinational),
//            mem_timeout (registered one-cycle pulse)
//   Macro HAZARD_STATS_EN adds stall_cycles / flush_events saturating counters.
module hazard_unit
  import core_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_memread,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              bubble,
  output logic              pipe_en,
  output logic              mem_timeout
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_events
`endif
);

  hz_state_t        state_q;
  hz_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             timeout_q;
  logic             timeout_d;
  logic             load_use;
  logic             mem_wait;

  // Hazard decode, control outputs and next-state; priority reset > wait > branch > load-use.
  always_comb begin
    load_use   = ex_memread && (ex_rd != '0) &&
                 ((id_use_rs1 && (ex_rd == id_rs1)) ||
                  (id_use_rs2 && (ex_rd == id_rs2)));
    mem_wait   = mem_req && !mem_ready;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    bubble     = 1'b0;
    pipe_en    = 1'b1;
    state_d    = HZ_RUN;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;

    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      pipe_en    = 1'b0;
      ifid_flush = 1'b1;
      bubble     = 1'b1;
    end else if (mem_wait) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
      state_d = HZ_MEM_WAIT;
      // Counter holds the number of wait cycles so far, so the entry cycle loads 1.
      if (state_q != HZ_MEM_WAIT) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Pulse only when the count newly arrives at the threshold (not while saturated on it).
      timeout_d = (cnt_d == CNT_W'(MEM_TIMEOUT)) &&
                  ((cnt_d != cnt_q) || (state_q != HZ_MEM_WAIT));
    end else if (branch_taken) begin
      // Squash the ID instruction; any load-use it had is moot.
      ifid_flush = 1'b1;
      bubble     = 1'b1;
    end else if (load_use) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      bubble  = 1'b1;
      state_d = HZ_LU_STALL;
    end
  end

  // State, wait counter and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HZ_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Held low during reset, including the cycle before the first reset edge.
  assign mem_timeout = timeout_q && !rst;

`ifdef HAZARD_STATS_EN
  // Reset clears via clr, so only non-reset cycles are counted.
  sat_counter #(.W(STAT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (!pc_en),
    .count (stall_cycles)
  );

  sat_counter #(.W(STAT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (ifid_flush),
    .count (flush_events)
  );
`endif

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RISC-V core, sitting in the ID stage directly upstream of the forwarding unit. Detects load-use hazards, taken-branch redirects and data-memory wait states. Drives the per-stage enable/flush controls and the `bubble` signal that the forwarding unit and the ID/EX register consume. Forwarding covers every RAW hazard except load-use; this block covers the rest.

## Interface
- `MEM_TIMEOUT`, 15: MEM_WAIT cycles before `mem_timeout` pulses; range 1..255.
- `clk` in 1: core clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1 each: the ID instruction actually reads that source.
- `ex_rd` in 5: destination register of the instruction in EX (ID/EX.rd).
- `ex_memread` in 1: instruction in EX is a load.
- `branch_taken` in 1: EX resolved a taken branch or jump this cycle.
- `mem_req` in 1: MEM stage is issuing a data access.
- `mem_ready` in 1: data memory completes the access this cycle.
- `pc_en` out 1: PC register enable.
- `ifid_en` out 1: IF/ID register enable.
- `ifid_flush` out 1: IF/ID loads a NOP.
- `bubble` out 1: ID/EX loads a NOP (regwrite=0, memread=0, memwrite=0); also drives the forwarding unit's `bubble` input.
- `pipe_en` out 1: enable for the ID/EX, EX/MEM and MEM/WB registers.
- `mem_timeout` out 1: one-cycle pulse when a wait reaches `MEM_TIMEOUT`.
- `stall_cycles`, `flush_events` out 16 each: present only with `HAZARD_STATS_EN`.

## Operation
- FSM states: RUN, LU_STALL, MEM_WAIT (encoded 2'b00, 2'b01, 2'b10).
- Load-use condition: `ex_memread` && `ex_rd` != 0 && ((`id_use_rs1` && `ex_rd`==`id_rs1`) || (`id_use_rs2` && `ex_rd`==`id_rs2`)).
- Wait condition: `mem_req` && !`mem_ready`.
- Priority, highest first: reset > wait > branch_taken > load-use.
- Wait, from any state:
  - All enables are 0 and both flushes are 0; the whole pipe freezes.
  - `branch_taken` and load-use are ignored.
  - Next state is MEM_WAIT.
- `branch_taken`, no wait:
  - `pc_en`=1, `ifid_en`=1, `ifid_flush`=1, `bubble`=1, `pipe_en`=1.
  - Next state is RUN.
  - A concurrent load-use is discarded, because the ID instruction is being squashed.
- Load-use, no wait or branch:
  - `pc_en`=0, `ifid_en`=0, `bubble`=1, `pipe_en`=1.
  - Next state is LU_STALL.
- Otherwise: all enables 1, no flush, `bubble`=0, next state RUN.
- LU_STALL:
  - Lasts exactly one cycle. The load has moved to MEM, so load-use cannot re-trigger for that load.
  - Outputs follow the same rules as RUN.
  - Exit to RUN, or to MEM_WAIT if the wait condition holds.
- MEM_WAIT: exit the cycle `mem_ready`=1. The RUN rules apply in that release cycle, including sampling `branch_taken` and load-use.
- Wait counter:
  - 8 bits; cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle.
  - `mem_timeout` pulses once when the count equals `MEM_TIMEOUT`.
  - Does not wrap; waiting continues indefinitely.

## Timing
- All control outputs are combinational from current state and inputs; the decision takes effect at the same-cycle edge, with zero latency.
- The FSM state, wait counter, `mem_timeout` and the statistics counters are registered.
- While `rst`=1:
  - `pc_en`=0, `ifid_en`=0, `pipe_en`=0.
  - `ifid_flush`=1, `bubble`=1.
  - `mem_timeout`=0.
- At the first edge with `rst`=1: state=RUN, wait counter=0, stats=0.
- Reset mid-MEM_WAIT or mid-LU_STALL abandons the operation; there is no pending flush carry-over.
- `mem_timeout` rises on the edge after the counter reaches `MEM_TIMEOUT` and is high for exactly one cycle.

## Configuration
- Macro: `HAZARD_STATS_EN`.
- Defined:
  - `stall_cycles` counts cycles with `pc_en`=0 outside reset, i.e. LU stalls plus MEM_WAIT.
  - `flush_events` counts cycles with `ifid_flush`=1 outside reset.
  - Both are 16-bit and saturate at 16'hFFFF.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

## Structure
- Shared package `core_pkg` holds:
  - the FSM state typedef `hz_state_t` and its encodings;
  - the `REG_W`=5 constant;
  - `STAT_W`=16.
- One sub-module, `sat_counter` (width-parameterised saturating counter with inc/clear), instantiated twice under `HAZARD_STATS_EN`.

## Test plan
- Load-use: `ex_memread`=1, `ex_rd`=5, `id_rs1`=5, `id_use_rs1`=1.
  - Cycle 0: `pc_en`=0, `ifid_en`=0, `bubble`=1; state LU_STALL.
  - Next cycle, with EX now a bubble: all enables 1.
  - Repeat with `ex_rd`=0: no stall.
- Branch plus load-use in the same cycle: `ifid_flush`=1, `bubble`=1, `pc_en`=1; state RUN; `flush_events` increments by 1.
- MEM wait of 3 cycles (`mem_req`=1, `mem_ready`=0 ×3, then 1):
  - `pc_en`/`pipe_en`=0 for 3 cycles, then 1 on the release cycle.
  - `stall_cycles`=3.
- Timeout with `MEM_TIMEOUT`=4 and a 10-cycle wait: `mem_timeout` high for exactly one cycle, after the 4th wait cycle; pipe stays frozen until `mem_ready`.
- `branch_taken`=1 during MEM_WAIT: ignored, no flush. On the release cycle with `branch_taken`=1: flush asserted.
- Assert `rst` during MEM_WAIT: enables 0, flushes 1. After deassert: RUN with enables 1 and counters 0.
